// File: rtl/cksum_check_pkg.sv
// cksum_check_pkg: shared widths, header size and FSM states for the
// checksum checker and the checksum generator.
package cksum_check_pkg;
   localparam int HDR_MAX_LEN = 32;
   localparam int BYTE_W      = 8;
   localparam int HALF_W      = 16;
   localparam int WORD_W      = 32;
   localparam int IDX_W       = $clog2(HDR_MAX_LEN);
   localparam int ADDR_W      = IDX_W + 1;
   typedef enum logic [2:0] {IDLE, SUM, FOLD, CHECK, DONE} state_t;
endpackage

// File: rtl/cksum_fold.sv
// cksum_fold: end-around fold of a 32-bit one's-complement accumulator to 16 bits.
module cksum_fold
   import cksum_check_pkg::*;
(
   input  logic [WORD_W-1:0] acc,
   output logic [HALF_W-1:0] sum
);
   logic [HALF_W:0] s;
   assign s   = {1'b0, acc[WORD_W-1:HALF_W]} + {1'b0, acc[HALF_W-1:0]};
   assign sum = s[HALF_W-1:0] + {{(HALF_W-1){1'b0}}, s[HALF_W]};
endmodule

// File: rtl/cksum_check.sv
// cksum_check: recomputes a 16-bit internet checksum over a header field
// and compares it with the checksum stored inside that field.
module cksum_check
   import cksum_check_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start_i,
   input  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0]   pkt_hdr_i,
   input  logic [ADDR_W-1:0]                    field_start_i,
   input  logic [31:0]                          field_len_i,
   input  logic [ADDR_W-1:0]                    cksum_off_i,
   output logic [HALF_W-1:0]                    cksum_calc_o,
   output logic                                 ok_o,
   output logic                                 err_o,
   output logic                                 busy_o,
   output logic                                 done_o
);
   state_t              state;
   logic [ADDR_W-1:0]   addr, end_a, off, nxt;
   logic [WORD_W-1:0]   acc;
   logic [HALF_W-1:0]   stored, folded, word;
   logic [BYTE_W-1:0]   hi, lo;
   logic [32:0]         end_w;
   logic                bad;

   // 33-bit end so a huge field_len_i cannot wrap back into range
   assign end_w = 33'(field_start_i) + {1'b0, field_len_i};
   assign bad   = end_w > 33'(HDR_MAX_LEN) || cksum_off_i < field_start_i ||
                  33'(cksum_off_i) + 33'd2 > end_w || (cksum_off_i[0] ^ field_start_i[0]);
   assign nxt    = addr + ADDR_W'(1);
   assign hi     = pkt_hdr_i[addr[IDX_W-1:0]];
   assign lo     = nxt < end_a ? pkt_hdr_i[nxt[IDX_W-1:0]] : '0;
   assign word   = addr == off ? '0 : {hi, lo};
   assign busy_o = state != IDLE;
   assign done_o = state == DONE;

   cksum_fold u_fold (.acc(acc), .sum(folded));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         addr         <= '0;
         end_a        <= '0;
         off          <= '0;
         acc          <= '0;
         stored       <= '0;
         cksum_calc_o <= '0;
         ok_o         <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               addr         <= field_start_i;
               end_a        <= end_w[ADDR_W-1:0];
               off          <= cksum_off_i;
               acc          <= '0;
               stored       <= '0;
               cksum_calc_o <= '0;
               ok_o         <= 1'b0;
               err_o        <= bad;
               state        <= bad ? DONE : SUM;
            end
            SUM: begin
               acc  <= acc + WORD_W'(word);
               addr <= addr + ADDR_W'(2);
               if (addr == off) stored <= {hi, lo};
               if (addr + ADDR_W'(2) >= end_a) state <= FOLD;
            end
            FOLD: begin
               acc   <= WORD_W'(acc[WORD_W-1:HALF_W]) + WORD_W'(acc[HALF_W-1:0]);
               state <= CHECK;
            end
            CHECK: begin
               cksum_calc_o <= ~folded;
               ok_o         <= stored == ~folded;
               err_o        <= 1'b0;
               state        <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cksum_check.sv
// tb_cksum_check: directed vectors against a byte-level one's-complement model,
// with a per-cycle compare of every output.
module tb_cksum_check;
   import cksum_check_pkg::*;

   logic                               clk, rst, start_i;
   logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] hdr;
   logic [ADDR_W-1:0]                  field_start_i, cksum_off_i;
   logic [31:0]                        field_len_i;
   logic [15:0]                        cksum_calc_o;
   logic                               ok_o, err_o, busy_o, done_o;

   int          vecs = 0, errs = 0, cyc = 0, acc_at = 0, exp_at = -1;
   logic [15:0] r_calc = 0, p_calc = 0;
   bit          r_ok = 0, r_err = 0, p_ok = 0, p_err = 0, chk_en = 0;

   cksum_check dut (
      .clk(clk), .rst(rst), .start_i(start_i), .pkt_hdr_i(hdr),
      .field_start_i(field_start_i), .field_len_i(field_len_i), .cksum_off_i(cksum_off_i),
      .cksum_calc_o(cksum_calc_o), .ok_o(ok_o), .err_o(err_o), .busy_o(busy_o), .done_o(done_o)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // outputs read 0 between acceptance and done, the new result from done on,
   // and the previous result before acceptance
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         check("done_o", done_o, cyc == exp_at);
         check("busy_o", busy_o, cyc >= acc_at && cyc <= exp_at);
         check("cksum_calc_o", cksum_calc_o, cyc >= exp_at ? r_calc : cyc >= acc_at ? 16'h0 : p_calc);
         check("ok_o", ok_o, cyc >= exp_at ? r_ok : cyc >= acc_at ? 1'b0 : p_ok);
         check("err_o", err_o, cyc >= exp_at ? r_err : cyc >= acc_at ? 1'b0 : p_err);
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic load(input logic [255:0] v, input int n);
      hdr = '0;
      for (int i = 0; i < n; i++) hdr[i] = v[(n-1-i)*8 +: 8];
   endtask

   function automatic void model(input int s, input longint l, input int o,
                                 output logic [15:0] c, output bit ok, output bit err, output int n);
      longint e = s + l;
      int sum = 0;
      logic [15:0] st;
      err = e > HDR_MAX_LEN || o < s || o + 2 > e || ((o - s) % 2 != 0);
      c = 0; ok = 0; n = 0;
      if (!err) begin
         for (int i = s; i < e; i++)
            if (i != o && i != o + 1) sum += ((i - s) % 2 == 0) ? int'(hdr[i]) << 8 : int'(hdr[i]);
         while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
         c  = ~16'(sum);
         st = {hdr[o], hdr[o+1]};
         ok = st == c;
         n  = int'((l + 1) / 2);
      end
   endfunction

   // drives one request from the current (idle) cycle and returns in the cycle after done;
   // poke re-pulses start while busy, dpoke pulses start in the done cycle
   task automatic run(input int s, input longint l, input int o, input int poke, input bit dpoke,
                      output logic [15:0] mc, output bit mok, output bit merr, output int lat);
      int n, k;
      model(s, l, o, mc, mok, merr, n);
      field_start_i = ADDR_W'(s);
      field_len_i   = l[31:0];
      cksum_off_i   = ADDR_W'(o);
      start_i       = 1;
      p_calc = r_calc; p_ok = r_ok; p_err = r_err;
      r_calc = mc;     r_ok = mok;  r_err = merr;
      acc_at = cyc + 1;
      exp_at = merr ? cyc + 1 : cyc + n + 3;
      lat    = exp_at - acc_at + 1;
      tick;
      start_i = 0;
      k = 1;
      while (cyc < exp_at) begin
         if (k == poke) begin
            start_i = 1; field_start_i = ADDR_W'(HDR_MAX_LEN - 2); field_len_i = 4;
         end else start_i = 0;
         tick;
         k++;
      end
      start_i = dpoke;
      tick;
      start_i = 0;
   endtask

   localparam logic [255:0] IPV4 = 256'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

   initial begin
      logic [15:0] c;
      bit ok, err;
      int lat;
      rst = 0; start_i = 0; field_start_i = 0; field_len_i = 0; cksum_off_i = 0; hdr = '0;
      repeat (2) tick;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_calc", cksum_calc_o, 0);
      check("rst_ok", ok_o, 0);
      check("rst_err", err_o, 0);

      load(IPV4, 20);
      rst = 1; chk_en = 1;
      run(0, 20, 10, 0, 0, c, ok, err, lat);
      check("ipv4_model_calc", c, 16'hB861);
      check("ipv4_model_ok", ok, 1);
      check("ipv4_latency", lat, 13);
      check("ipv4_dut_calc", cksum_calc_o, 16'hB861);

      hdr[8] = 8'h41;
      run(0, 20, 10, 0, 0, c, ok, err, lat);
      check("ipv4_bad_model_calc", c, 16'hB761);
      check("ipv4_bad_dut_ok", ok_o, 0);

      load(256'h010203, 3);
      run(0, 3, 0, 0, 0, c, ok, err, lat);
      check("odd_model_calc", c, 16'hFCFF);
      check("odd_latency", lat, 5);
      check("odd_dut_calc", cksum_calc_o, 16'hFCFF);

      load(256'hFFFF_FFFF_0000, 6);
      run(0, 6, 4, 0, 0, c, ok, err, lat);
      check("carry_model_calc", c, 16'h0000);
      check("carry_dut_ok", ok_o, 1);

      run(HDR_MAX_LEN - 2, 4, HDR_MAX_LEN - 2, 0, 0, c, ok, err, lat);
      check("over_end_err", err_o, 1);
      check("over_end_latency", lat, 1);

      load(IPV4, 20);
      run(0, 20, 1, 0, 0, c, ok, err, lat);
      check("odd_off_err", err_o, 1);
      run(0, 0, 0, 0, 0, c, ok, err, lat);
      check("zero_len_err", err_o, 1);
      run(4, 64'hFFFF_FFFE, 4, 0, 0, c, ok, err, lat);
      check("huge_len_err", err_o, 1);
      run(0, 20, 20, 0, 0, c, ok, err, lat);
      check("off_past_end_err", err_o, 1);
      run(0, 20, 18, 0, 0, c, ok, err, lat);
      run(2, 17, 6, 0, 0, c, ok, err, lat);

      run(0, 20, 10, 3, 1, c, ok, err, lat);
      check("busy_poke_dut_calc", cksum_calc_o, 16'hB861);

      // abort mid-SUM with an asynchronous reset
      chk_en = 0;
      field_start_i = 0; field_len_i = 20; cksum_off_i = 10; start_i = 1;
      tick;
      start_i = 0;
      repeat (2) tick;
      check("pre_abort_busy", busy_o, 1);
      rst = 0;
      #1;
      check("abort_busy", busy_o, 0);
      check("abort_calc", cksum_calc_o, 0);
      check("abort_ok", ok_o, 0);
      check("abort_err", err_o, 0);
      repeat (15) begin
         tick;
         check("abort_no_done", done_o, 0);
      end
      rst = 1;
      p_calc = 0; p_ok = 0; p_err = 0; r_calc = 0; r_ok = 0; r_err = 0;
      acc_at = 0; exp_at = -1; chk_en = 1;
      run(0, 20, 10, 0, 0, c, ok, err, lat);
      check("after_abort_calc", cksum_calc_o, 16'hB861);
      check("after_abort_ok", ok_o, 1);
      repeat (3) tick;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d miscompares so far", errs);
      $fatal(1);
   end
endmodule
